// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus receiver: HD44780-style command opcodes,
// character-buffer geometry, the controller state enum and a cursor-step helper.
package lcd_pkg;

  // Command opcode bases; a command belongs to the highest base it reaches.
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam int         BUF_DEPTH   = 32;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } lcd_state_e;

  // Linear 5-bit index space: wraps 31->0 on increment and 0->31 on decrement.
  function automatic logic [4:0] step_cursor(input logic [4:0] cur, input logic inc);
    return inc ? (cur + 5'd1) : (cur - 5'd1);
  endfunction

endpackage

// File: rtl/lcd_strobe_detect.sv
// Synchronizes the asynchronous LCD bus (RS, RW, EN, DATA) into clk, measures
// the synchronized EN high width and flags each falling edge as either a valid
// strobe (high for at least MIN_EN_HIGH cycles) or a short, discarded pulse.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   lcd_rs/rw/en/data     - raw bus inputs
//   strobe_valid          - 1-cycle pulse on a qualified EN falling edge
//   strobe_short          - 1-cycle pulse on a too-short EN falling edge
//   strobe_rs/rw/data     - bus fields captured on the last EN-high cycle
module lcd_strobe_detect #(
  parameter int MIN_EN_HIGH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic       strobe_valid,
  output logic       strobe_short,
  output logic       strobe_rs,
  output logic       strobe_rw,
  output logic [7:0] strobe_data
);

  localparam int             CW      = (MIN_EN_HIGH < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_EN_HIGH);

  // Bus packing: [10]=RS, [9]=RW, [8]=EN, [7:0]=DATA
  logic [10:0]   sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    samp_q, samp_d;
  logic          en_s, fall;

  always_comb begin
    en_s  = sync2_q[8];
    // Counter saturates at the threshold; it only needs to tell "long enough".
    cnt_d = cnt_q;
    if (en_s) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    // Keep overwriting while EN is high so the last high cycle's fields remain.
    samp_d = samp_q;
    if (en_s) samp_d = {sync2_q[10:9], sync2_q[7:0]};
    fall = !en_s && (cnt_q != '0);
  end

  assign strobe_valid = fall && (cnt_q >= CNT_MAX);
  assign strobe_short = fall && (cnt_q <  CNT_MAX);
  assign strobe_rs    = samp_q[9];
  assign strobe_rw    = samp_q[8];
  assign strobe_data  = samp_q[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      samp_q  <= '0;
    end else begin
      sync1_q <= {lcd_rs, lcd_rw, lcd_en, lcd_data};
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receives writes from an HD44780-style parallel LCD bus and maintains a
// 32-entry character buffer (two lines of 16) plus cursor/display state.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   LCD_ON              - panel power; strobes ignored when low
//   LCD_RS/RW/EN/DATA   - LCD bus (asynchronous to clk)
//   rd_addr / rd_char   - buffer read port, 1-cycle registered latency
//   cursor              - current write index
//   display_on          - display-on bit from last display-control command
//   busy                - high while the buffer clear runs
//   cmd_count           - accepted commands + data writes, wraps at 256
//   protocol_err        - sticky error flag, cleared only by reset
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int MIN_EN_HIGH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_ON,
  input  logic       LCD_RS,
  input  logic       LCD_EN,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       busy,
  output logic [7:0] cmd_count,
  output logic       protocol_err
);

  logic       strobe_valid, strobe_short, strobe_rs, strobe_rw;
  logic [7:0] strobe_data;

  lcd_strobe_detect #(.MIN_EN_HIGH(MIN_EN_HIGH)) u_strobe (
    .clk          (clk),
    .reset        (reset),
    .lcd_rs       (LCD_RS),
    .lcd_rw       (LCD_RW),
    .lcd_en       (LCD_EN),
    .lcd_data     (LCD_DATA),
    .strobe_valid (strobe_valid),
    .strobe_short (strobe_short),
    .strobe_rs    (strobe_rs),
    .strobe_rw    (strobe_rw),
    .strobe_data  (strobe_data)
  );

  logic [7:0] mem [BUF_DEPTH];

  lcd_state_e state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [4:0] cursor_q, cursor_d;
  logic       inc_q, inc_d;
  logic       display_on_q, display_on_d;
  logic [7:0] cmd_count_q, cmd_count_d;
  logic       err_q, err_d;
  logic [7:0] rd_char_q;

  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       strobe_live;
  logic [6:0] ddram_addr;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    display_on_d = display_on_q;
    cmd_count_d  = cmd_count_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = cursor_q;
    mem_wdata    = strobe_data;
    ddram_addr   = strobe_data[6:0];
    // With the panel off the bus is treated as idle noise: no action, no error.
    strobe_live  = strobe_valid && LCD_ON;

    unique case (state_q)
      ST_CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = BLANK_CHAR;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'(BUF_DEPTH - 1)) begin
          state_d  = ST_IDLE;
          cursor_d = '0;
          inc_d    = 1'b1;
        end
        // Strobes during a clear are dropped uncounted.
        if (strobe_live) err_d = 1'b1;
      end

      default: begin
        if (strobe_live) begin
          if (strobe_rw) begin
            err_d = 1'b1;
          end else if (strobe_rs) begin
            mem_we      = 1'b1;
            cursor_d    = step_cursor(cursor_q, inc_q);
            cmd_count_d = cmd_count_q + 8'd1;
          end else if (strobe_data >= CMD_DDRAM) begin
            if (ddram_addr[6:4] == 3'b000) begin
              cursor_d    = {1'b0, ddram_addr[3:0]};
              cmd_count_d = cmd_count_q + 8'd1;
            end else if (ddram_addr[6:4] == LINE2_BASE[6:4]) begin
              cursor_d    = {1'b1, ddram_addr[3:0]};
              cmd_count_d = cmd_count_q + 8'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cmd_count_d = cmd_count_q + 8'd1;
            if (strobe_data >= CMD_SHIFT) begin
              // Shift, function set and CGRAM addressing have no modelled effect.
            end else if (strobe_data >= CMD_DISPLAY) begin
              display_on_d = strobe_data[2];
            end else if (strobe_data >= CMD_ENTRY) begin
              inc_d = strobe_data[1];
            end else if (strobe_data >= CMD_HOME) begin
              cursor_d = '0;
            end else if (strobe_data == CMD_CLEAR) begin
              state_d   = ST_CLEARING;
              clr_idx_d = '0;
            end
          end
        end
      end
    endcase

    // A too-short pulse is a protocol error regardless of state.
    if (strobe_short && LCD_ON) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= '0;
      cursor_q     <= '0;
      inc_q        <= 1'b1;
      display_on_q <= 1'b0;
      cmd_count_q  <= '0;
      err_q        <= 1'b0;
      rd_char_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      display_on_q <= display_on_d;
      cmd_count_q  <= cmd_count_d;
      err_q        <= err_d;
      rd_char_q    <= mem[rd_addr];
    end
  end

  // Buffer contents survive reset; the write port is gated so a reset
  // landing mid-clear stops the clear on that same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_char      = rd_char_q;
  assign cursor       = cursor_q;
  assign display_on   = display_on_q;
  assign busy         = (state_q == ST_CLEARING);
  assign cmd_count    = cmd_count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;

  localparam int MIN_EN_HIGH = 2;

  logic       clk = 1'b0;
  logic       reset, lcd_on, lcd_rs, lcd_en, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       display_on, busy, protocol_err;
  logic [7:0] cmd_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } rd_t;

  rd_t req_q[$];
  rd_t sb_q[$];

  // Reference model of the visible state
  logic [7:0] m_buf [32];
  logic [4:0] m_cursor;
  logic       m_inc;
  logic [7:0] m_count;

  lcd_bus_receiver #(.MIN_EN_HIGH(MIN_EN_HIGH)) dut (
    .clk          (clk),
    .reset        (reset),
    .LCD_ON       (lcd_on),
    .LCD_RS       (lcd_rs),
    .LCD_EN       (lcd_en),
    .LCD_RW       (lcd_rw),
    .LCD_DATA     (lcd_data),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .cursor       (cursor),
    .display_on   (display_on),
    .busy         (busy),
    .cmd_count    (cmd_count),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_strobe(input logic rs, input logic rw, input logic [7:0] d,
                             input int hi, input int settle);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = d;
    lcd_en   = 1'b1;
    repeat (hi) tick();
    lcd_en = 1'b0;
    repeat (settle) tick();
  endtask

  task automatic model_write(input logic rs, input logic [7:0] d);
    logic [6:0] a;
    a = d[6:0];
    if (rs) begin
      m_buf[m_cursor] = d;
      m_cursor = m_inc ? m_cursor + 5'd1 : m_cursor - 5'd1;
      m_count++;
    end else if (d >= 8'h80) begin
      if (a <= 7'h0F) begin
        m_cursor = a[4:0];
        m_count++;
      end else if (a >= 7'h40 && a <= 7'h4F) begin
        m_cursor = 5'd16 + 5'(a - 7'h40);
        m_count++;
      end
    end else begin
      m_count++;
      if (d == 8'h02 || d == 8'h03) m_cursor = 5'd0;
      else if (d >= 8'h04 && d <= 8'h07) m_inc = d[1];
    end
  endtask

  task automatic write_bus(input logic rs, input logic [7:0] d);
    send_strobe(rs, 1'b0, d, MIN_EN_HIGH, 4);
    model_write(rs, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    m_cursor = 5'd0;
    m_inc    = 1'b1;
    m_count  = 8'd0;
    tick();
  endtask

  task automatic expect_read(input logic [4:0] addr);
    rd_t r;
    r.addr = addr;
    r.exp  = m_buf[addr];
    req_q.push_back(r);
  endtask

  // Drive queued read addresses one per cycle; results come back a cycle later.
  task automatic drain_reads(input string tag);
    rd_t r, e;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      rd_addr = r.addr;
      sb_q.push_back(r);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (rd_char !== e.exp) begin
        errors++;
        $display("FAIL %s rd[%0d]: got %h expected %h", tag, e.addr, rd_char, e.exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks += 6;
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (cursor !== 5'd0)       begin errors++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    if (display_on !== 1'b0)   begin errors++; $display("FAIL reset_display: got %b expected 0", display_on); end
    if (cmd_count !== 8'd0)    begin errors++; $display("FAIL reset_count: got %0d expected 0", cmd_count); end
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", protocol_err); end
    if (rd_char !== 8'h00)     begin errors++; $display("FAIL reset_rdchar: got %h expected 00", rd_char); end
    reset = 1'b0;
    m_cursor = 5'd0;
    m_inc    = 1'b1;
    m_count  = 8'd0;
    tick();
  endtask

  task automatic test_basic_write();
    write_bus(1'b0, 8'h80);
    write_bus(1'b1, 8'h48);
    write_bus(1'b1, 8'h49);
    checks += 2;
    if (cursor !== 5'd2)    begin errors++; $display("FAIL basic_cursor: got %0d expected 2", cursor); end
    if (cmd_count !== 8'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", cmd_count); end
    expect_read(5'd0);
    expect_read(5'd1);
    drain_reads("basic");
  endtask

  task automatic test_line2();
    write_bus(1'b0, 8'hC5);
    write_bus(1'b1, 8'h41);
    checks++;
    if (cursor !== 5'd22) begin errors++; $display("FAIL line2_cursor: got %0d expected 22", cursor); end
    // End of line 2 then increment wraps to 0
    write_bus(1'b0, 8'hCF);
    write_bus(1'b1, 8'h42);
    checks += 2;
    if (cursor !== 5'd0) begin errors++; $display("FAIL wrap_cursor: got %0d expected 0", cursor); end
    if (cmd_count !== m_count) begin errors++; $display("FAIL line2_count: got %0d expected %0d", cmd_count, m_count); end
    expect_read(5'd21);
    expect_read(5'd31);
    drain_reads("line2");
  endtask

  task automatic test_clear();
    int wait_cnt, busy_cnt;
    write_bus(1'b0, 8'h8A);   // move cursor away from 0 first
    send_strobe(1'b0, 1'b0, 8'h01, MIN_EN_HIGH, 0);
    wait_cnt = 0;
    while (!busy && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (!busy) begin errors++; $display("FAIL clear_start: busy got 0 expected 1 within 20 cycles"); end
    busy_cnt = 0;
    while (busy && busy_cnt < 100) begin
      // A data strobe in the middle of the clear must be dropped.
      if (busy_cnt == 3) begin
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h5A; lcd_en = 1'b1;
      end
      if (busy_cnt == 6) lcd_en = 1'b0;
      busy_cnt++;
      tick();
    end
    lcd_en = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_cursor = 5'd0;
    m_inc    = 1'b1;
    m_count++;
    checks += 4;
    if (busy_cnt != 32)        begin errors++; $display("FAIL clear_busy_len: got %0d expected 32", busy_cnt); end
    if (cursor !== 5'd0)       begin errors++; $display("FAIL clear_cursor: got %0d expected 0", cursor); end
    if (cmd_count !== m_count) begin errors++; $display("FAIL clear_count: got %0d expected %0d", cmd_count, m_count); end
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL clear_busy_err: got %b expected 1", protocol_err); end
    for (int i = 0; i < 32; i++) expect_read(5'(i));
    drain_reads("clear");
  endtask

  task automatic test_reset_abort();
    int wait_cnt;
    do_reset();
    checks++;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", protocol_err); end
    expect_read(5'd5);
    expect_read(5'd20);
    drain_reads("rst_keep");
    send_strobe(1'b0, 1'b0, 8'h01, MIN_EN_HIGH, 0);
    wait_cnt = 0;
    while (!busy && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", busy); end
    m_cursor = 5'd0;
    m_inc    = 1'b1;
    m_count  = 8'd0;
  endtask

  task automatic test_decrement();
    do_reset();
    write_bus(1'b0, 8'h04);
    write_bus(1'b0, 8'h80);
    write_bus(1'b1, 8'h58);
    checks++;
    if (cursor !== 5'd31) begin errors++; $display("FAIL dec_cursor: got %0d expected 31", cursor); end
    write_bus(1'b1, 8'h59);
    checks++;
    if (cursor !== 5'd30) begin errors++; $display("FAIL dec_cursor2: got %0d expected 30", cursor); end
    expect_read(5'd0);
    expect_read(5'd31);
    expect_read(5'd30);
    drain_reads("dec");
  endtask

  task automatic test_errors();
    do_reset();
    send_strobe(1'b1, 1'b0, 8'h77, 1, 4);
    checks += 3;
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", protocol_err); end
    if (cmd_count !== 8'd0)    begin errors++; $display("FAIL short_count: got %0d expected 0", cmd_count); end
    if (cursor !== 5'd0)       begin errors++; $display("FAIL short_cursor: got %0d expected 0", cursor); end
    expect_read(5'd0);
    drain_reads("short");

    do_reset();
    send_strobe(1'b1, 1'b1, 8'h66, MIN_EN_HIGH, 4);
    checks += 3;
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL rw_err: got %b expected 1", protocol_err); end
    if (cmd_count !== 8'd0)    begin errors++; $display("FAIL rw_count: got %0d expected 0", cmd_count); end
    if (cursor !== 5'd0)       begin errors++; $display("FAIL rw_cursor: got %0d expected 0", cursor); end
    expect_read(5'd0);
    drain_reads("rw");

    do_reset();
    lcd_on = 1'b0;
    send_strobe(1'b1, 1'b0, 8'h66, MIN_EN_HIGH, 4);
    lcd_on = 1'b1;
    checks += 3;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL off_err: got %b expected 0", protocol_err); end
    if (cmd_count !== 8'd0)    begin errors++; $display("FAIL off_count: got %0d expected 0", cmd_count); end
    if (cursor !== 5'd0)       begin errors++; $display("FAIL off_cursor: got %0d expected 0", cursor); end
    expect_read(5'd0);
    drain_reads("off");
  endtask

  task automatic test_display();
    do_reset();
    write_bus(1'b0, 8'h0C);
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL disp_on: got %b expected 1", display_on); end
    write_bus(1'b0, 8'h08);
    checks++;
    if (display_on !== 1'b0) begin errors++; $display("FAIL disp_off: got %b expected 0", display_on); end
    write_bus(1'b0, 8'h83);
    write_bus(1'b0, 8'h90);
    checks += 3;
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL badaddr_err: got %b expected 1", protocol_err); end
    if (cursor !== 5'd3)       begin errors++; $display("FAIL badaddr_cursor: got %0d expected 3", cursor); end
    if (cmd_count !== 8'd3)    begin errors++; $display("FAIL badaddr_count: got %0d expected 3", cmd_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    write_bus(1'b0, 8'h80);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(8'h21, 8'h7E));
      send_strobe(1'b1, 1'b0, d, MIN_EN_HIGH, 1);
      model_write(1'b1, d);
    end
    repeat (4) tick();
    checks += 2;
    if (cursor !== m_cursor)   begin errors++; $display("FAIL b2b_cursor: got %0d expected %0d", cursor, m_cursor); end
    if (cmd_count !== m_count) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", cmd_count, m_count); end
    for (int i = 0; i < 11; i++) expect_read(5'(i));
    drain_reads("b2b");
  endtask

  initial begin
    reset = 1'b1; lcd_on = 1'b1; lcd_rs = 1'b0; lcd_en = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h00; rd_addr = 5'd0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h00;
    m_cursor = 5'd0; m_inc = 1'b1; m_count = 8'd0;
    test_reset();
    test_basic_write();
    test_line2();
    test_clear();
    test_reset_abort();
    test_decrement();
    test_errors();
    test_display();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
